bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/bus_arbiter.sv | 127 ++++++++++++
 tb/tb_bus_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM states, master id, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Master id: 0 = CPU core, 1 = DMA/debug loader.
  typedef logic mid_t;

  localparam mid_t M0 = 1'b0;
  localparam mid_t M1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: chooses which requesting master wins this arbitration.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is used.
// Ports: req[1:0] request per master; last = master granted most recently; winner = chosen master.
module rr_arbiter2
  import bus_pkg::*;
(
  input  logic [1:0] req,
  input  mid_t       last,
  output mid_t       winner
);

  always_comb begin
    winner = M0;
    if (req == 2'b11) begin
      // Tie: the master that did not win last time goes next.
      winner = mid_t'(~last);
    end else if (req[1]) begin
      winner = M1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates two masters onto one shared slave bus, one transaction at a time.
// Latency: req sampled in IDLE at edge N -> s_valid in cycle N+1 -> done in cycle N+2; one txn per 3 cycles.
// Backpressure: a losing or late master simply keeps req high; requests are only sampled in IDLE.
// Ports: clk/reset (async, active low); per-master req, wr_en, addr, wdata in and done, rdata out;
//        shared slave bus s_valid, s_wr_en, s_addr, s_wdata out and s_rdata in; busy/owner status.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr_en,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr_en,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic              s_wr_en,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              busy,
  output logic              owner
);

  state_t            state_q, state_d;
  mid_t              owner_q, owner_d;
  mid_t              last_q, last_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  mid_t              winner;

  rr_arbiter2 u_rr (
    .req    ({m1_req, m0_req}),
    .last   (last_q),
    .winner (winner)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // Latch the winner's command so later changes on its inputs are ignored.
          owner_d = winner;
          last_d  = winner;
          wr_d    = (winner == M1) ? m1_wr_en : m0_wr_en;
          addr_d  = (winner == M1) ? m1_addr  : m0_addr;
          wdata_d = (winner == M1) ? m1_wdata : m0_wdata;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // s_rdata is combinational from the interconnect; capture it as ACCESS ends.
        if (!wr_q) begin
          if (owner_q == M1) begin
            m1_rdata_d = s_rdata;
          end else begin
            m0_rdata_d = s_rdata;
          end
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= M0;
      // Pointer starts at m1 so m0 wins the first tie.
      last_q     <= M1;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

  // All outputs decode from flops, so reset clears them without waiting for a clock edge.
  assign s_valid  = (state_q == ACCESS);
  assign s_wr_en  = s_valid && wr_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign busy     = (state_q != IDLE);
  assign owner    = owner_q;
  assign m0_done  = (state_q == RESP) && (owner_q == M0);
  assign m1_done  = (state_q == RESP) && (owner_q == M1);
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected transactions are queued when driven, checked on s_valid/done.
// Latency: expects s_valid one cycle and done two cycles after the sampling edge.
// Backpressure: n/a.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr_en, m1_req, m1_wr_en;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_done, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_wr_en;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic        busy, owner;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr_en(m0_wr_en), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr_en(m1_wr_en), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_wr_en(s_wr_en), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        m;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          t;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] model_rd [2];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Queue one expected transaction; t is the cycle in which s_valid must be seen.
  task automatic push_exp(input logic m, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd, input int t);
    exp_t e;
    e.m = m; e.wr = wr; e.addr = addr; e.wdata = wdata; e.t = t;
    if (!wr) model_rd[m] = rd;
    e.rdata = model_rd[m];
    sb.push_back(e);
  endtask

  task automatic drive_m(input logic m, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata);
    if (m) begin
      m1_wr_en = wr; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_wr_en = wr; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_pending", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Monitor: outputs all come from DUT flops, so sampling on the falling edge is race free.
  always @(negedge clk) begin
    if (reset) begin
      if (m0_done && m1_done) chk("dual_done", 32'd1, 32'd0);
      if (!s_valid && s_wr_en) chk("wr_en_outside_access", 32'(s_wr_en), 32'd0);
      if (s_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          mon_e = sb[0];
          chk("s_wr_en", 32'(s_wr_en), 32'(mon_e.wr));
          chk("s_addr", s_addr, mon_e.addr);
          if (mon_e.wr) chk("s_wdata", s_wdata, mon_e.wdata);
          chk("valid_cycle", 32'(cyc), 32'(mon_e.t));
          chk("busy_access", 32'(busy), 32'd1);
          chk("owner_access", 32'(owner), 32'(mon_e.m));
        end
      end
      if (m0_done || m1_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("done_master", 32'(m1_done), 32'(mon_e.m));
          chk("rdata", mon_e.m ? m1_rdata : m0_rdata, mon_e.rdata);
          chk("done_cycle", 32'(cyc), 32'(mon_e.t + 1));
          chk("busy_resp", 32'(busy), 32'd1);
          chk("owner_resp", 32'(owner), 32'(mon_e.m));
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0;
    drive_m(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m(1'b1, 1'b0, 32'h0, 32'h0);
    s_rdata = 32'h0;
    model_rd[0] = 32'h0; model_rd[1] = 32'h0;
    #1;
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_s_wr_en", 32'(s_wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_m0_done", 32'(m0_done), 32'd0);
    chk("rst_m1_done", 32'(m1_done), 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // m1 read: rdata from the bus lands in m1_rdata only.
    drive_m(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    s_rdata = 32'h0000_000A;
    m1_req = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0000_1000, 32'h0, 32'h0000_000A, cyc + 1);
    @(negedge clk);
    m1_req = 1'b0;
    wait_empty();
    chk("m0_rdata_after_m1_read", m0_rdata, 32'd0);

    // m0 read so its rdata is nonzero before the write.
    drive_m(1'b0, 1'b0, 32'h0000_0030, 32'h0);
    s_rdata = 32'h0000_0055;
    m0_req = 1'b1;
    push_exp(1'b0, 1'b0, 32'h0000_0030, 32'h0, 32'h0000_0055, cyc + 1);
    @(negedge clk);
    m0_req = 1'b0;
    wait_empty();

    // m0 write: bus data must not be captured.
    drive_m(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    s_rdata = 32'hFFFF_FFFF;
    m0_req = 1'b1;
    push_exp(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, cyc + 1);
    @(negedge clk);
    m0_req = 1'b0;
    wait_empty();
    chk("m1_rdata_held", m1_rdata, 32'h0000_000A);

    // Inputs changing during ACCESS are ignored.
    drive_m(1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111);
    m0_req = 1'b1;
    push_exp(1'b0, 1'b1, 32'h0000_0010, 32'h1111_1111, 32'h0, cyc + 1);
    @(negedge clk);
    drive_m(1'b0, 1'b0, 32'h0000_0020, 32'h2222_2222);
    m0_req = 1'b0;
    wait_empty();

    // Fresh reset, then both masters held high for 12 cycles: m0, m1, m0, m1.
    reset = 1'b0;
    model_rd[0] = 32'h0; model_rd[1] = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    drive_m(1'b0, 1'b1, 32'h0000_0100, 32'hA0A0_0000);
    drive_m(1'b1, 1'b1, 32'h0000_0200, 32'hB1B1_0000);
    m0_req = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i[0]) push_exp(1'b1, 1'b1, 32'h0000_0200, 32'hB1B1_0000, 32'h0, cyc + 1 + 3 * i);
      else      push_exp(1'b0, 1'b1, 32'h0000_0100, 32'hA0A0_0000, 32'h0, cyc + 1 + 3 * i);
    end
    repeat (12) @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    wait_empty();

    // m0 write aborted by reset mid-ACCESS; last grant before reset is m0.
    drive_m(1'b0, 1'b1, 32'h0000_0300, 32'h3333_3333);
    m0_req = 1'b1;
    push_exp(1'b0, 1'b1, 32'h0000_0300, 32'h3333_3333, 32'h0, cyc + 1);
    @(negedge clk);
    m0_req = 1'b0;
    chk("pre_reset_valid", 32'(s_valid), 32'd1);
    #1;
    reset = 1'b0;
    sb.delete();
    model_rd[0] = 32'h0; model_rd[1] = 32'h0;
    #1;
    chk("abort_s_valid", 32'(s_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_m0_done", 32'(m0_done), 32'd0);
    chk("abort_s_wr_en", 32'(s_wr_en), 32'd0);
    repeat (3) @(negedge clk);
    // Release with a tie already pending: pointer reset means m0 wins.
    drive_m(1'b1, 1'b1, 32'h0000_0500, 32'h5555_5555);
    m0_req = 1'b1; m1_req = 1'b1;
    reset = 1'b1;
    push_exp(1'b0, 1'b1, 32'h0000_0300, 32'h3333_3333, 32'h0, cyc + 1);
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    wait_empty();

    // m1 held continuously: done every 3 cycles.
    drive_m(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    s_rdata = 32'h0000_0077;
    m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_exp(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0000_0077, cyc + 1 + 3 * i);
    end
    repeat (10) @(negedge clk);
    m1_req = 1'b0;
    wait_empty();
    chk("final_m1_rdata", m1_rdata, 32'h0000_0077);
    chk("final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
